// File: rtl/updown_counter_ext.sv
// Parametrised up/down counter with enable, synchronous load and step.
// Wraps or clamps at the range limits, with registered boundary pulse.
module updown_counter_ext #(
    parameter int unsigned       WIDTH     = 32,
    parameter int unsigned       STEP_W    = 8,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0,
    parameter bit                SATURATE  = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic              inst,
    input  logic [STEP_W-1:0] step,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    output logic [WIDTH-1:0]  value,
    output logic              wrapped,
    output logic              at_max,
    output logic              at_min
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;
    localparam logic [WIDTH-1:0] MIN_VAL = '0;

    logic [WIDTH-1:0] value_q, value_d;
    logic             wrapped_q, wrapped_d;

    logic [WIDTH:0]   step_ext;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   dn_diff;
    logic             carry;
    logic             borrow;

    // One extra bit exposes carry/borrow of the update.
    assign step_ext = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
    assign up_sum   = {1'b0, value_q} + step_ext;
    assign dn_diff  = {1'b0, value_q} - step_ext;
    assign carry    = up_sum[WIDTH];
    assign borrow   = dn_diff[WIDTH];

    // Next-state selection: load beats count, idle clears the pulse.
    always_comb begin
        value_d   = value_q;
        wrapped_d = 1'b0;
        if (load) begin
            value_d = load_val;
        end else if (en && !inst) begin
            if (carry) begin
                value_d   = SATURATE ? MAX_VAL : up_sum[WIDTH-1:0];
                wrapped_d = 1'b1;
            end else begin
                value_d = up_sum[WIDTH-1:0];
            end
        end else if (en && inst) begin
            if (borrow) begin
                value_d   = SATURATE ? MIN_VAL : dn_diff[WIDTH-1:0];
                wrapped_d = 1'b1;
            end else begin
                value_d = dn_diff[WIDTH-1:0];
            end
        end
    end

    // Value and boundary pulse registers, async reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value_q   <= RESET_VAL;
            wrapped_q <= 1'b0;
        end else begin
            value_q   <= value_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign value   = value_q;
    assign wrapped = wrapped_q;
    assign at_max  = (value_q == MAX_VAL);
    assign at_min  = (value_q == MIN_VAL);

endmodule

// File: tb/tb_updown_counter_ext.sv
// Directed checks of updown_counter_ext across four configurations.
// Instances share stimulus; each check targets the relevant instance.
module tb_updown_counter_ext;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        inst = 1'b0;
    logic [7:0]  step = '0;
    logic        load = 1'b0;
    logic [31:0] load_val = '0;

    logic [31:0] v32;
    logic        w32, mx32, mn32;
    logic [7:0]  v8w;
    logic        w8w, mx8w, mn8w;
    logic [7:0]  v8s;
    logic        w8s, mx8s, mn8s;
    logic [3:0]  v4;
    logic        w4, mx4, mn4;

    int n_chk = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    updown_counter_ext #(.WIDTH(32), .STEP_W(8), .SATURATE(1'b0)) u32 (
        .clock(clock), .reset(reset), .en(en), .inst(inst),
        .step(step), .load(load), .load_val(load_val),
        .value(v32), .wrapped(w32), .at_max(mx32), .at_min(mn32)
    );

    updown_counter_ext #(.WIDTH(8), .STEP_W(8), .SATURATE(1'b0)) u8w (
        .clock(clock), .reset(reset), .en(en), .inst(inst),
        .step(step), .load(load), .load_val(load_val[7:0]),
        .value(v8w), .wrapped(w8w), .at_max(mx8w), .at_min(mn8w)
    );

    updown_counter_ext #(.WIDTH(8), .STEP_W(8), .SATURATE(1'b1)) u8s (
        .clock(clock), .reset(reset), .en(en), .inst(inst),
        .step(step), .load(load), .load_val(load_val[7:0]),
        .value(v8s), .wrapped(w8s), .at_max(mx8s), .at_min(mn8s)
    );

    updown_counter_ext #(.WIDTH(4), .STEP_W(4), .SATURATE(1'b0)) u4 (
        .clock(clock), .reset(reset), .en(en), .inst(inst),
        .step(step[3:0]), .load(load), .load_val(load_val[3:0]),
        .value(v4), .wrapped(w4), .at_max(mx4), .at_min(mn4)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_v32", v32, 32'h0);
        chk("rst_w32", 32'(w32), 32'h0);
        chk("rst_min32", 32'(mn32), 32'h1);
        chk("rst_v8s", 32'(v8s), 32'h0);
        tick();
        reset = 1'b0;

        // 1: count 5, async reset mid-count, resume
        en = 1'b1; inst = 1'b0; step = 8'd1;
        repeat (5) tick();
        chk("up5_v32", v32, 32'd5);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_v32", v32, 32'd0);
        reset = 1'b0;
        tick();
        chk("resume1", v32, 32'd1);
        tick();
        chk("resume2", v32, 32'd2);
        tick();
        chk("resume3", v32, 32'd3);

        // 2: wrap up in 8-bit modular
        load = 1'b1; load_val = 32'hFE;
        tick();
        chk("ld_v8w", 32'(v8w), 32'hFE);
        load = 1'b0; step = 8'd3;
        tick();
        chk("wrap_v8w", 32'(v8w), 32'h01);
        chk("wrap_w8w", 32'(w8w), 32'h1);
        chk("sat_up_v8s", 32'(v8s), 32'hFF);
        chk("sat_up_max8s", 32'(mx8s), 32'h1);
        step = 8'd1;
        tick();
        chk("post_v8w", 32'(v8w), 32'h02);
        chk("post_w8w", 32'(w8w), 32'h0);

        // 3: saturate down in 8-bit clamp
        load = 1'b1; load_val = 32'h02;
        tick();
        load = 1'b0; inst = 1'b1; step = 8'd5;
        tick();
        chk("satdn_v8s", 32'(v8s), 32'h00);
        chk("satdn_w8s", 32'(w8s), 32'h1);
        chk("satdn_min8s", 32'(mn8s), 32'h1);
        chk("wrapdn_v8w", 32'(v8w), 32'hFD);
        tick();
        chk("satdn2_v8s", 32'(v8s), 32'h00);
        chk("satdn2_w8s", 32'(w8s), 32'h1);
        inst = 1'b0; step = 8'd1;
        tick();
        chk("rev_v8s", 32'(v8s), 32'h01);
        chk("rev_w8s", 32'(w8s), 32'h0);

        // 4: load beats count
        load = 1'b1; load_val = 32'h1234; en = 1'b1;
        inst = 1'b1; step = 8'd7;
        tick();
        chk("prio_v32", v32, 32'h1234);
        chk("prio_w32", 32'(w32), 32'h0);

        // 5: hold via en=0 and step=0
        load = 1'b0; en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_v32", v32, 32'h1234);
        end
        en = 1'b1; step = 8'd0;
        tick();
        chk("step0_v32", v32, 32'h1234);
        chk("step0_w32", 32'(w32), 32'h0);

        // 6: flags in 4-bit modular
        load = 1'b1; load_val = 32'hF;
        tick();
        chk("ld_v4", 32'(v4), 32'hF);
        chk("ld_max4", 32'(mx4), 32'h1);
        chk("ld_min4", 32'(mn4), 32'h0);
        load = 1'b0; inst = 1'b0; step = 8'd1;
        tick();
        chk("up_v4", 32'(v4), 32'h0);
        chk("up_min4", 32'(mn4), 32'h1);
        chk("up_w4", 32'(w4), 32'h1);
        inst = 1'b1;
        tick();
        chk("dn_v4", 32'(v4), 32'hF);
        chk("dn_w4", 32'(w4), 32'h1);
        chk("dn_max4", 32'(mx4), 32'h1);

        // 32-bit underflow from zero
        load = 1'b1; load_val = 32'h0;
        tick();
        load = 1'b0; step = 8'd2;
        tick();
        chk("uf_v32", v32, 32'hFFFF_FFFE);
        chk("uf_w32", 32'(w32), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
